// File: rtl/mc_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller: FSM states,
// instruction classes, exact-match opcodes and the ALU/PC select encodings.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    I_LDUR,
    I_STUR,
    I_CBZ,
    I_B,
    I_RTYPE,
    I_ILL
  } iclass_t;

  // Fully specified opcodes; CBZ and B carry don't-care low bits and are
  // matched by pattern in the decoder.
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_HOLD   = 2'b10;

  function automatic logic is_mem_class(input iclass_t c);
    return (c == I_LDUR) || (c == I_STUR);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle: opcode, flags, ready handshakes,
// datapath strobes and performance counters. master = controller side.
interface mc_if #(
  parameter int unsigned CNT_W = 32
);

  logic [10:0]      opcode;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;

  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg2loc;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             illegal_op;
  logic             bus_error;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, illegal_op, bus_error,
           cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, illegal_op, bus_error,
           cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational IR[31:21] -> instruction class; also usable by the
// sign-extender owner to pick the immediate field.
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [10:0] opcode_i,
  output iclass_t     iclass_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    iclass_o = I_ILL;
    casez (opcode_i)
      OP_LDUR:                         iclass_o = I_LDUR;
      OP_STUR:                         iclass_o = I_STUR;
      11'b10110100???:                 iclass_o = I_CBZ;
      11'b000101?????:                 iclass_o = I_B;
      OP_ADD, OP_SUB, OP_AND, OP_ORR:  iclass_o = I_RTYPE;
      default:                         iclass_o = I_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with memory-ready
// timeouts. Define MC_PERF_CNT_EN to build the cycle/instruction counters.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  localparam int unsigned        WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  iclass_t           iclass_q;
  logic [WAIT_W-1:0] wait_q;

  iclass_t dec_class;
  logic    mem_ready;
  logic    waiting;
  logic    timeout;

  mc_opcode_decode u_decode (
    .opcode_i (bus.opcode),
    .iclass_o (dec_class)
  );

  assign mem_ready = (state_q == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  // A ready in the last allowed cycle keeps waiting low, so it beats the timeout.
  assign timeout   = waiting && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      iclass_q <= I_ILL;
      wait_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block order-independent.
      wait_q <= (waiting && !timeout) ? wait_q + 1'b1 : '0;
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (bus.imem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          iclass_q <= dec_class;
          state_q  <= (dec_class == I_ILL) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          if (is_mem_class(iclass_q))    state_q <= S_MEM;
          else if (iclass_q == I_RTYPE)  state_q <= S_WB;
          else                           state_q <= S_FETCH;
        end
        S_MEM: begin
          if (bus.dmem_ready)  state_q <= (iclass_q == I_LDUR) ? S_WB : S_FETCH;
          else if (timeout)    state_q <= S_FETCH;
        end
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SRC_HOLD;
    bus.reg2loc    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = ALU_OP_ADD;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.illegal_op = 1'b0;
    bus.bus_error  = 1'b0;
    case (state_q)
      // IDLE is the reset state, where every output including pc_src reads 0.
      S_IDLE: bus.pc_src = PC_SRC_SEQ;
      S_FETCH: begin
        bus.imem_req  = 1'b1;
        bus.ir_write  = bus.imem_ready;
        bus.bus_error = timeout;
      end
      S_DECODE: begin
        if (dec_class == I_ILL) begin
          bus.illegal_op = 1'b1;
          bus.pc_write   = 1'b1;
          bus.pc_src     = PC_SRC_SEQ;
        end
      end
      S_EXEC: begin
        case (iclass_q)
          I_LDUR, I_STUR: bus.alu_src = 1'b1;
          I_RTYPE:        bus.alu_op  = ALU_OP_RTYPE;
          I_CBZ: begin
            bus.reg2loc  = 1'b1;
            bus.alu_op   = ALU_OP_PASSB;
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
          end
          I_B: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_SRC_BRANCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_read  = (iclass_q == I_LDUR);
        bus.mem_write = (iclass_q == I_STUR);
        bus.bus_error = timeout;
        if ((iclass_q == I_STUR) && bus.dmem_ready) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_SEQ;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (iclass_q == I_LDUR);
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_SRC_SEQ;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             retire;

  // Skipped (illegal) instructions also write the PC but do not retire.
  assign retire  = bus.pc_write && !bus.illegal_op;
  assign cycle_d = cycle_q + 1'b1;
  assign instr_d = instr_q + CNT_W'(retire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
`else
  assign bus.cycle_cnt = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: a transaction-level
// model expands each instruction into its expected per-cycle strobe sequence.
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int CW = 32;

  typedef enum {C_LDUR, C_STUR, C_CBZ, C_B, C_RTYPE, C_ILL} cls_e;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg2loc;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       bus_error;
  } strobe_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad   = 0;
  int unsigned n_edges;
  int unsigned exp_instr = 0;

  mc_if #(.CNT_W(CW)) bus ();

  multicycle_control #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic rbit();
    int unsigned r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic logic [10:0] rop();
    int unsigned r;
    r = $urandom;
    return r[10:0];
  endfunction

  function automatic cls_e classify(input logic [10:0] op);
    if (op == 11'b11111000010) return C_LDUR;
    if (op == 11'b11111000000) return C_STUR;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    if (op inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000})
      return C_RTYPE;
    return C_ILL;
  endfunction

  function automatic logic [10:0] pick_op();
    int unsigned r;
    logic [10:0] x;
    r = $urandom_range(0, 9);
    x = rop();
    case (r)
      0: return 11'b11111000010;
      1: return 11'b11111000000;
      2: return {8'b10110100, x[2:0]};
      3: return {6'b000101, x[4:0]};
      4: return 11'b10001011000;
      5: return 11'b11001011000;
      6: return 11'b10001010000;
      7: return 11'b10101010000;
      default: return x;
    endcase
  endfunction

  // Quiet cycle: nothing written, PC held.
  function automatic strobe_t base();
    strobe_t s;
    s        = '0;
    s.pc_src = 2'b10;
    return s;
  endfunction

  function automatic logic [31:0] observe();
    strobe_t s;
    s.imem_req   = bus.imem_req;
    s.ir_write   = bus.ir_write;
    s.pc_write   = bus.pc_write;
    s.pc_src     = bus.pc_src;
    s.reg2loc    = bus.reg2loc;
    s.alu_src    = bus.alu_src;
    s.alu_op     = bus.alu_op;
    s.mem_read   = bus.mem_read;
    s.mem_write  = bus.mem_write;
    s.mem_to_reg = bus.mem_to_reg;
    s.reg_write  = bus.reg_write;
    s.illegal_op = bus.illegal_op;
    s.bus_error  = bus.bus_error;
    return {17'd0, s};
  endfunction

  function automatic logic [31:0] exp_cyc();
`ifdef MC_PERF_CNT_EN
    return n_edges;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_ins();
`ifdef MC_PERF_CNT_EN
    return exp_instr;
`else
    return 32'd0;
`endif
  endfunction

  // One clock cycle: drive inputs at the falling edge, check just after.
  task automatic step(input string tag, input logic [10:0] op, input logic z,
                      input logic ir, input logic dr, input strobe_t e, input logic retire);
    @(negedge clk);
    reset          = 1'b0;
    bus.opcode     = op;
    bus.zero       = z;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    #1;
    check(tag, observe(), {17'd0, e});
    check({tag, "_cyc"}, bus.cycle_cnt, exp_cyc());
    check({tag, "_ins"}, bus.instr_cnt, exp_ins());
    if (retire) exp_instr++;
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      bus.opcode     = rop();
      bus.zero       = rbit();
      bus.imem_ready = rbit();
      bus.dmem_ready = rbit();
      #1;
      check("rst_strobes", observe(), 32'd0);
      check("rst_cyc", bus.cycle_cnt, 32'd0);
      check("rst_ins", bus.instr_cnt, 32'd0);
    end
    exp_instr = 0;
    step("idle", rop(), rbit(), rbit(), rbit(), strobe_t'('0), 1'b0);
  endtask

  // f_wait: FETCH cycles before imem_ready; m_wait: MEM cycles before
  // dmem_ready; abort_at: MEM cycle at which reset is applied (-1 = never).
  task automatic run_instr(input string tag, input logic [10:0] op, input logic z,
                           input int f_wait, input int m_wait, input int abort_at);
    cls_e    c;
    strobe_t e;
    logic    rdy;
    c = classify(op);

    // Every TO-th unanswered fetch cycle times out and restarts the fetch.
    for (int g = 0; g <= f_wait; g++) begin
      e          = base();
      e.imem_req = 1'b1;
      rdy        = (g == f_wait);
      if (rdy) e.ir_write = 1'b1;
      else if ((g % TO) == TO - 1) e.bus_error = 1'b1;
      step({tag, "_fetch"}, rop(), rbit(), rdy, rbit(), e, 1'b0);
    end

    e = base();
    if (c == C_ILL) begin
      e.illegal_op = 1'b1;
      e.pc_write   = 1'b1;
      e.pc_src     = 2'b00;
    end
    step({tag, "_dec"}, op, rbit(), rbit(), rbit(), e, 1'b0);
    if (c == C_ILL) return;

    e = base();
    case (c)
      C_LDUR, C_STUR: e.alu_src = 1'b1;
      C_RTYPE:        e.alu_op  = 2'b10;
      C_CBZ: begin
        e.reg2loc  = 1'b1;
        e.alu_op   = 2'b01;
        e.pc_write = 1'b1;
        e.pc_src   = z ? 2'b01 : 2'b00;
      end
      default: begin
        e.pc_write = 1'b1;
        e.pc_src   = 2'b01;
      end
    endcase
    step({tag, "_exec"}, rop(), z, rbit(), rbit(), e, (c == C_CBZ) || (c == C_B));
    if ((c == C_CBZ) || (c == C_B)) return;

    if ((c == C_LDUR) || (c == C_STUR)) begin
      for (int g = 0; g <= m_wait; g++) begin
        if (g == abort_at) begin
          reset_seq();
          return;
        end
        e           = base();
        e.mem_read  = (c == C_LDUR);
        e.mem_write = (c == C_STUR);
        rdy         = (g == m_wait);
        if (rdy && (c == C_STUR)) begin
          e.pc_write = 1'b1;
          e.pc_src   = 2'b00;
        end else if (!rdy && (g == TO - 1)) begin
          e.bus_error = 1'b1;
        end
        step({tag, "_mem"}, rop(), rbit(), rbit(), rdy, e, rdy && (c == C_STUR));
        if (e.bus_error || (rdy && (c == C_STUR))) return;
      end
    end

    e            = base();
    e.reg_write  = 1'b1;
    e.mem_to_reg = (c == C_LDUR);
    e.pc_write   = 1'b1;
    e.pc_src     = 2'b00;
    step({tag, "_wb"}, rop(), rbit(), rbit(), rbit(), e, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode     = '0;
    bus.zero       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    reset_seq();

    run_instr("add",      11'b10001011000, 1'b0, 0, 0, -1);
    run_instr("ldur_w3",  11'b11111000010, 1'b0, 0, 3, -1);
    run_instr("cbz_z1",   11'b10110100101, 1'b1, 0, 0, -1);
    run_instr("cbz_z0",   11'b10110100010, 1'b0, 0, 0, -1);
    run_instr("ill",      11'b11111111111, 1'b0, 0, 0, -1);
    run_instr("b_fto",    11'b00010110011, 1'b0, 5, 0, -1);
    run_instr("sub_race", 11'b11001011000, 1'b0, 3, 0, -1);
    run_instr("ldur_race",11'b11111000010, 1'b0, 0, 3, -1);
    run_instr("stur_mto", 11'b11111000000, 1'b0, 0, 6, -1);
    run_instr("stur",     11'b11111000000, 1'b0, 1, 0, -1);
    run_instr("stur_rst", 11'b11111000000, 1'b0, 0, 3, 1);
    run_instr("orr_post", 11'b10101010000, 1'b0, 0, 0, -1);
    run_instr("and_post", 11'b10001010000, 1'b1, 2, 0, -1);

    for (int i = 0; i < 300; i++) begin
      run_instr("rnd", pick_op(), rbit(), $urandom_range(0, 6), $urandom_range(0, 5), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
